pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central control for the 5-stage pipeline's pipeline registers. Drives the write-enable (regWrite-style) and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB Register instances.
- Handles load-use stalls, taken-branch flushes, multi-cycle multiply/divide occupancy and global memory wait.
- Sits beside the datapath. Consumes decode/execute hazard info; produces per-stage enables plus a saturating stall-cycle counter for CPI measurement.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MD_LATENCY, 4, total EX cycles of a multiply/divide op (legal range 2..15).
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs  in  REG_ADDR_W  rs of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt of the instruction in ID.
- id_usesRt  in  1  ID instruction reads rt.
- ex_memRead  in  1  EX instruction is a load.
- ex_rt  in  REG_ADDR_W  destination of the EX load.
- ex_branchTaken  in  1  branch resolved taken in EX.
- ex_mdStart  in  1  EX instruction is mult/div, first EX cycle.
- mem_wait  in  1  memory not ready; freeze whole pipeline.
- pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite  out  1 each  register write enables.
- ifidFlush, idexFlush, exmemFlush  out  1 each  load-bubble (zero) into that register.
- md_busy  out  1  multi-cycle unit occupying EX.
- md_done  out  1  one-cycle pulse, last MD cycle.
- stall_cycles  out  CNT_W  count of cycles with pcWrite=0.

Behaviour:
- States: RUN, MD_BUSY. Counter md_cnt is 4 bits.
- Outputs are combinational from state, md_cnt and inputs. state, md_cnt and stall_cycles are registered.
- Reset (async, any time, including mid-MD): state=RUN, md_cnt=0, stall_cycles=0. Outputs settle to the RUN decode; with all inputs 0 this is all enables=1, all flushes=0, md_busy=0, md_done=0.
- Decode priority, highest first: mem_wait, MD_BUSY, branch, load-use, normal.
- mem_wait=1:
  - All five enables=0, all flushes=0.
  - State and md_cnt hold; MD countdown pauses.
  - stall_cycles increments.
- MD_BUSY (mem_wait=0):
  - pcWrite=ifidWrite=idexWrite=0, exmemWrite=memwbWrite=1, exmemFlush=1 (bubbles drain to MEM/WB), md_busy=1.
  - md_cnt decrements each cycle.
  - When md_cnt==0: md_done=1, exmemFlush=0 (result written), next state RUN.
  - Branch and load-use inputs are ignored.
- RUN, ex_mdStart=1 (mem_wait=0): next state MD_BUSY with md_cnt=MD_LATENCY-2. This cycle is treated as a normal cycle with all enables=1. ex_branchTaken and ex_mdStart are never simultaneously 1; if they are, the MD transition takes effect and the branch still flushes.
- RUN, ex_branchTaken=1: all enables=1, ifidFlush=1, idexFlush=1. Any load-use condition in the same cycle is suppressed.
- RUN, load-use: condition is ex_memRead && ex_rt!=0 && (ex_rt==id_rs || (id_usesRt && ex_rt==id_rt)).
  - pcWrite=0, ifidWrite=0, idexFlush=1; other enables=1.
  - Exactly one bubble. The next cycle re-evaluates with the new EX contents.
- stall_cycles: increments on every cycle with pcWrite=0 and saturates at all-ones.
- Total front-end freeze per MD op = MD_LATENCY-1 cycles, plus any mem_wait cycles.

Decomposition:
- Shared package cpu_ctrl_pkg holds the state encoding (RUN=0, MD_BUSY=1), REG_ADDR_W, and the zero-register constant.
- One natural sub-module, hazard_detect: the pure-combinational load-use comparator. The FSM, counters and output decode stay in the top.

Test Plan:
- Reset release with all inputs 0 → all five enables=1, flushes=0, stall_cycles=0; assert reset mid-MD → state RUN immediately, md_busy=0.
- ex_memRead=1, ex_rt=5, id_rs=5 → one cycle with pcWrite=0, ifidWrite=0, idexFlush=1; stall_cycles=1. Repeat with ex_rt=0 → no stall.
- ex_memRead=1, ex_rt=7, id_rt=7, id_usesRt=0 → no stall. Same with id_usesRt=1 → stall.
- ex_branchTaken=1 together with load-use match → ifidFlush=idexFlush=1, pcWrite=1, stall_cycles unchanged.
- ex_mdStart pulse with MD_LATENCY=4 → md_busy high 3 cycles, md_done on the 3rd, exmemFlush high for the first 2; stall_cycles=3.
- mem_wait=1 for 2 cycles in the middle of MD_BUSY → all enables 0 and md_cnt frozen; md_done is delayed 2 cycles; stall_cycles=5.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
// Holds the hazard-controller state encoding, the default register-specifier
// width and the architectural zero-register specifier.
package cpu_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // Writes to the zero register are discarded, so a load targeting it can
  // never create a real data dependence.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator (pure combinational).
// Flags when the load currently in EX writes a register that the
// instruction in ID is about to read.
// Ports:
//   ex_memRead - EX instruction is a load
//   ex_rt      - destination register of the EX load
//   id_rs      - rs of the ID instruction (always read)
//   id_rt      - rt of the ID instruction
//   id_usesRt  - ID instruction actually reads rt
//   load_use   - hazard present this cycle
module hazard_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_usesRt,
  output logic                  load_use
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  // Compare the load destination against both ID source specifiers.
  always_comb begin
    dest_live = (ex_rt != REG_ADDR_W'(ZERO_REG));
    rs_match  = (ex_rt == id_rs);
    // rt only matters when the ID instruction really reads it (e.g. not
    // for immediate forms where rt is the destination).
    rt_match  = id_usesRt && (ex_rt == id_rt);
    load_use  = ex_memRead && dest_live && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline-register control for the 5-stage pipeline.
// Produces write enables and bubble (flush) controls for the PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB registers, handling memory wait, multi-cycle
// multiply/divide occupancy, taken-branch flushes and load-use stalls,
// and counts front-end stall cycles for CPI measurement.
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   id_rs, id_rt, id_usesRt          - source info of the ID instruction
//   ex_memRead, ex_rt                - load info of the EX instruction
//   ex_branchTaken, ex_mdStart       - EX branch outcome / MD op start
//   mem_wait                          - memory not ready, freeze all
//   pcWrite..memwbWrite               - pipeline register write enables
//   ifidFlush, idexFlush, exmemFlush  - load a bubble into that register
//   md_busy, md_done                  - MD occupancy / last-cycle pulse
//   stall_cycles                      - saturating count of pcWrite=0 cycles
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_ctrl_pkg::REG_ADDR_W,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_usesRt,
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branchTaken,
  input  logic                  ex_mdStart,
  input  logic                  mem_wait,
  output logic                  pcWrite,
  output logic                  ifidWrite,
  output logic                  idexWrite,
  output logic                  exmemWrite,
  output logic                  memwbWrite,
  output logic                  ifidFlush,
  output logic                  idexFlush,
  output logic                  exmemFlush,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [CNT_W-1:0]      stall_cycles
);

  // The start cycle counts as the first EX cycle and the cycle with
  // md_cnt==0 is the last, so the countdown starts at MD_LATENCY-2.
  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_e state;
  ctrl_state_e next_state;
  logic [3:0]  md_cnt;
  logic [3:0]  next_md_cnt;
  logic        load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_memRead (ex_memRead),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_usesRt  (id_usesRt),
    .load_use   (load_use)
  );

  // State and MD countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= next_state;
      md_cnt <= next_md_cnt;
    end
  end

  // Next-state and output decode; priority mem_wait > MD_BUSY > branch >
  // load-use > normal.
  always_comb begin
    next_state  = state;
    next_md_cnt = md_cnt;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    idexWrite   = 1'b1;
    exmemWrite  = 1'b1;
    memwbWrite  = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    exmemFlush  = 1'b0;
    md_busy     = (state == MD_BUSY);
    md_done     = 1'b0;

    if (mem_wait) begin
      // Whole pipeline frozen; state and countdown simply hold.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
      memwbWrite = 1'b0;
    end else begin
      case (state)
        MD_BUSY: begin
          // Front end frozen behind the MD op; bubbles drain into MEM until
          // the final cycle, when the real result is written to EX/MEM.
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexWrite = 1'b0;
          if (md_cnt == 4'd0) begin
            md_done    = 1'b1;
            next_state = RUN;
          end else begin
            exmemFlush  = 1'b1;
            next_md_cnt = md_cnt - 4'd1;
          end
        end
        RUN: begin
          if (ex_mdStart) begin
            next_state  = MD_BUSY;
            next_md_cnt = MD_INIT;
          end else begin
            next_state  = RUN;
          end
          if (ex_branchTaken) begin
            // Wrong-path instructions in IF and ID are squashed; any
            // load-use against the squashed ID instruction is irrelevant.
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (load_use && !ex_mdStart) begin
            // Hold PC and IF/ID, insert one bubble into ID/EX.
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
          end else begin
            pcWrite   = 1'b1;
          end
        end
        default: begin
          next_state  = RUN;
          next_md_cnt = 4'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pcWrite && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a behavioural model computes
// the expected control word and stall count for each driven cycle, pushes it
// to a scoreboard queue, and a negedge sampler pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic       id_usesRt = 1'b0, ex_memRead = 1'b0, ex_branchTaken = 1'b0;
  logic       ex_mdStart = 1'b0, mem_wait = 1'b0;
  logic       pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
  logic       ifidFlush, idexFlush, exmemFlush, md_busy, md_done;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [9:0]  ctl;
    logic [31:0] stall;
  } exp_t;
  exp_t sb[$];

  // Model state
  bit m_busy = 1'b0;
  int m_cnt = 0;
  int unsigned m_stall = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_usesRt(id_usesRt), .ex_memRead(ex_memRead), .ex_rt(ex_rt),
    .ex_branchTaken(ex_branchTaken), .ex_mdStart(ex_mdStart),
    .mem_wait(mem_wait), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .idexWrite(idexWrite), .exmemWrite(exmemWrite), .memwbWrite(memwbWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_ctl();
    return {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite,
            ifidFlush, idexFlush, exmemFlush, md_busy, md_done};
  endfunction

  // Scoreboard sampler: outputs are compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val({e.tag, ".ctl"}, {22'd0, dut_ctl()}, {22'd0, e.ctl});
      check_val({e.tag, ".stall"}, stall_cycles, e.stall);
    end
  end

  // Drive one cycle of inputs, predict outputs, advance the model.
  task automatic step(input string tag, input bit mw, input bit br, input bit md,
                      input bit mr, input bit urt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] ert);
    exp_t e;
    bit lu;
    @(posedge clk);
    #1;
    mem_wait = mw; ex_branchTaken = br; ex_mdStart = md; ex_memRead = mr;
    id_usesRt = urt; id_rs = rs; id_rt = rt; ex_rt = ert;
    lu = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
    e.tag = tag;
    e.stall = m_stall;
    if (mw) begin
      e.ctl = {5'b00000, 3'b000, m_busy, 1'b0};
    end else if (m_busy) begin
      e.ctl = {5'b00011, 2'b00, (m_cnt != 0), 1'b1, (m_cnt == 0)};
      if (m_cnt == 0) m_busy = 1'b0;
      else m_cnt--;
    end else begin
      if (br)                e.ctl = 10'b11111_110_00;
      else if (lu && !md)    e.ctl = 10'b00111_010_00;
      else                   e.ctl = 10'b11111_000_00;
      if (md) begin
        m_busy = 1'b1;
        m_cnt = LAT - 2;
      end
    end
    if (e.ctl[9] == 1'b0 && m_stall != 32'hFFFF_FFFF) m_stall++;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_val("reset.ctl", {22'd0, dut_ctl()}, {22'd0, 10'b11111_000_00});
    check_val("reset.stall", stall_cycles, 32'd0);

    idle("idle0");
    step("lu_rs", 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5);
    idle("after_lu_rs");
    step("lu_zero", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step("rt_nouse", 0, 0, 0, 1, 0, 5'd0, 5'd7, 5'd7);
    step("rt_use", 0, 0, 0, 1, 1, 5'd0, 5'd7, 5'd7);
    idle("after_rt_use");
    step("br_lu", 0, 1, 0, 1, 0, 5'd3, 5'd0, 5'd3);
    idle("after_br");

    step("md_start", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step("md_b1", 0, 1, 0, 1, 0, 5'd4, 5'd0, 5'd4);
    idle("md_b2");
    idle("md_b3");
    idle("md_after");

    step("md2_start", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle("md2_b1");
    step("md2_w1", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step("md2_w2", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle("md2_b2");
    idle("md2_b3");
    idle("md2_after");

    step("run_wait", 1, 0, 1, 1, 0, 5'd2, 5'd0, 5'd2);
    idle("run_after_wait");

    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    // Reset asserted while an MD op is in flight.
    step("md3_start", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle("md3_b1");
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_val("midmd_reset.md_busy", {31'd0, md_busy}, 32'd0);
    check_val("midmd_reset.ctl", {22'd0, dut_ctl()}, {22'd0, 10'b11111_000_00});
    check_val("midmd_reset.stall", stall_cycles, 32'd0);
    #2 reset = 1'b0;
    m_busy = 1'b0;
    m_cnt = 0;
    m_stall = 0;
    idle("post_reset");
    step("post_reset_lu", 0, 0, 0, 1, 1, 5'd0, 5'd9, 5'd9);
    idle("post_reset_end");

    @(negedge clk);
    #1;
    check_val("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
